// File: rtl/eth_reg_arbiter_pkg.sv
// Shared constants, state encoding and RegIO bundle type for the KSZ8851 register-bus arbiter.
package eth_reg_arbiter_pkg;

   localparam int unsigned N_REQ  = 3;
   localparam int unsigned OFS_W  = 8;
   localparam int unsigned DAT_W  = 16;
   localparam int unsigned MST_W  = 2;
   localparam int unsigned RST_W  = 4;
   localparam int unsigned CNT_W  = 8;

   localparam logic [MST_W-1:0] MASTER_INIT  = 2'b00;
   localparam logic [MST_W-1:0] MASTER_TRANS = 2'b01;
   localparam logic [MST_W-1:0] MASTER_RECV  = 2'b10;
   localparam logic [MST_W-1:0] MASTER_IDLE  = 2'b11;

   localparam logic [RST_W-1:0] REG_IDLE = 4'd0;

   localparam int unsigned REQ_INIT  = 0;
   localparam int unsigned REQ_TRANS = 1;
   localparam int unsigned REQ_RECV  = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DRAIN = 2'd2
   } arb_state_t;

   // Everything RegIO needs for one command, as presented by one requester.
   typedef struct packed {
      logic [OFS_W-1:0] offset;
      logic             length;
      logic             wr;
      logic [DAT_W-1:0] wdata;
      logic             newcmd;
      logic             dummy_wr;
      logic             dummy_rd;
   } regio_bus_t;

   localparam regio_bus_t REGIO_IDLE = '{
      offset: '0, length: 1'b1, wr: 1'b0, wdata: '0,
      newcmd: 1'b0, dummy_wr: 1'b0, dummy_rd: 1'b0
   };

endpackage

// File: rtl/eth_reg_mux.sv
// Combinational select of the RegIO command bundle by master code; code 11 gives the idle bundle.
module eth_reg_mux
   import eth_reg_arbiter_pkg::*;
(
   input  logic [MST_W-1:0] master,
   input  regio_bus_t       bus_init,
   input  regio_bus_t       bus_trans,
   input  regio_bus_t       bus_recv,
   output regio_bus_t       bus_out
);

   // Four-way select; unknown/idle codes fall back to the idle bundle.
   always_comb begin
      bus_out = REGIO_IDLE;
      case (master)
         MASTER_INIT:  bus_out = bus_init;
         MASTER_TRANS: bus_out = bus_trans;
         MASTER_RECV:  bus_out = bus_recv;
         default:      bus_out = REGIO_IDLE;
      endcase
   end

endmodule

// File: rtl/eth_reg_arbiter.sv
// Request/grant arbiter sharing the KSZ8851 RegIO engine among init, transmit and receive,
// with init-first gating, transmit/receive round robin and a stalled-grantee watchdog.
module eth_reg_arbiter
   import eth_reg_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 4096,
   parameter int unsigned TO_W        = 13
) (
   input  logic                   sysclk,
   input  logic                   reset,
   input  logic                   init_done,
   input  logic [N_REQ-1:0]       req,
   output logic [N_REQ-1:0]       grant,
   output logic [MST_W-1:0]       master,
   input  logic [N_REQ*OFS_W-1:0] offset_i,
   input  logic [N_REQ-1:0]       length_i,
   input  logic [N_REQ-1:0]       wr_i,
   input  logic [N_REQ-1:0]       newcmd_i,
   input  logic [N_REQ*DAT_W-1:0] wdata_i,
   input  logic                   dummy_wr_i,
   input  logic                   dummy_rd_i,
   output logic [OFS_W-1:0]       offset,
   output logic                   length,
   output logic                   WR,
   output logic [DAT_W-1:0]       writeData,
   output logic                   NewCommand,
   output logic                   Dummy_Write,
   output logic                   Dummy_Read,
   input  logic [RST_W-1:0]       reg_state,
   output logic                   timeout_err,
   output logic [CNT_W-1:0]       timeout_cnt
);

   localparam logic [N_REQ-1:0] ELIG_PRE  = 3'b001;
   localparam logic [N_REQ-1:0] ELIG_POST = 3'b110;
   localparam logic [TO_W-1:0]  WD_LAST   = TO_W'(TIMEOUT_CYC - 1);

   arb_state_t        state_q, state_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic [MST_W-1:0]  master_q, master_d;
   logic              rr_recv_q, rr_recv_d;
   logic [TO_W-1:0]   wd_q, wd_d;
   logic              init_q;
   logic [N_REQ-1:0]  mask_q, mask_set;
   logic              fire;
   logic              to_err_q;
   logic [CNT_W-1:0]  to_cnt_q;

   logic [N_REQ-1:0]  elig;
   logic [MST_W-1:0]  pick;
   logic              g_req;
   logic              activity;
   logic              busy;
   regio_bus_t        bus_init, bus_trans, bus_recv, bus_sel;

   // Unpack each requester's command fields; only the owner of a dummy strobe carries it.
   always_comb begin
      bus_init  = '{offset: offset_i[OFS_W*REQ_INIT +: OFS_W], length: length_i[REQ_INIT],
                    wr: wr_i[REQ_INIT], wdata: wdata_i[DAT_W*REQ_INIT +: DAT_W],
                    newcmd: newcmd_i[REQ_INIT], dummy_wr: 1'b0, dummy_rd: 1'b0};
      bus_trans = '{offset: offset_i[OFS_W*REQ_TRANS +: OFS_W], length: length_i[REQ_TRANS],
                    wr: wr_i[REQ_TRANS], wdata: wdata_i[DAT_W*REQ_TRANS +: DAT_W],
                    newcmd: newcmd_i[REQ_TRANS], dummy_wr: dummy_wr_i, dummy_rd: 1'b0};
      bus_recv  = '{offset: offset_i[OFS_W*REQ_RECV +: OFS_W], length: length_i[REQ_RECV],
                    wr: wr_i[REQ_RECV], wdata: wdata_i[DAT_W*REQ_RECV +: DAT_W],
                    newcmd: newcmd_i[REQ_RECV], dummy_wr: 1'b0, dummy_rd: dummy_rd_i};
   end

   eth_reg_mux u_mux (
      .master    (master_q),
      .bus_init  (bus_init),
      .bus_trans (bus_trans),
      .bus_recv  (bus_recv),
      .bus_out   (bus_sel)
   );

   // Next-state, grant selection and watchdog decisions.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      master_d  = master_q;
      rr_recv_d = rr_recv_q;
      wd_d      = '0;
      mask_set  = '0;
      fire      = 1'b0;

      elig = init_q ? (req & ~mask_q & ELIG_POST) : (req & ~mask_q & ELIG_PRE);

      pick = MASTER_TRANS;
      if (elig[REQ_INIT])                         pick = MASTER_INIT;
      else if (elig[REQ_TRANS] && elig[REQ_RECV]) pick = rr_recv_q ? MASTER_RECV : MASTER_TRANS;
      else if (elig[REQ_RECV])                    pick = MASTER_RECV;

      g_req = 1'b0;
      case (master_q)
         MASTER_INIT:  g_req = req[REQ_INIT];
         MASTER_TRANS: g_req = req[REQ_TRANS];
         MASTER_RECV:  g_req = req[REQ_RECV];
         default:      g_req = 1'b0;
      endcase

      activity = bus_sel.newcmd || (reg_state != REG_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (|elig) begin
               state_d  = ST_BUSY;
               grant_d  = N_REQ'(3'b001 << pick);
               master_d = pick;
               if (pick == MASTER_RECV)  rr_recv_d = 1'b0;
               if (pick == MASTER_TRANS) rr_recv_d = 1'b1;
            end
         end
         ST_BUSY: begin
            if (!g_req) begin
               state_d = ST_DRAIN;
               grant_d = '0;
            end else if (activity) begin
               wd_d = '0;
            end else if (wd_q == WD_LAST) begin
               state_d  = ST_DRAIN;
               grant_d  = '0;
               mask_set = grant_q;
               fire     = 1'b1;
            end else begin
               wd_d = wd_q + TO_W'(1);
            end
         end
         ST_DRAIN: begin
            if (reg_state == REG_IDLE) begin
               state_d  = ST_IDLE;
               master_d = MASTER_IDLE;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            grant_d  = '0;
            master_d = MASTER_IDLE;
         end
      endcase
   end

   // State, grant, pointer, watchdog, mask and revocation bookkeeping.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         master_q  <= MASTER_IDLE;
         rr_recv_q <= 1'b1;
         wd_q      <= '0;
         init_q    <= 1'b0;
         mask_q    <= '0;
         to_err_q  <= 1'b0;
         to_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         master_q  <= master_d;
         rr_recv_q <= rr_recv_d;
         wd_q      <= wd_d;
         init_q    <= init_q | init_done;
         mask_q    <= (mask_q & req) | mask_set;
         to_err_q  <= fire;
         if (fire && (to_cnt_q != {CNT_W{1'b1}})) to_cnt_q <= to_cnt_q + CNT_W'(1);
      end
   end

   // Strobes pass only while a grant is live; address/data follow the last master into drain.
   always_comb begin
      busy        = (state_q == ST_BUSY);
      grant       = grant_q;
      master      = master_q;
      offset      = bus_sel.offset;
      length      = bus_sel.length;
      WR          = bus_sel.wr;
      writeData   = bus_sel.wdata;
      NewCommand  = busy & bus_sel.newcmd;
      Dummy_Write = busy & bus_sel.dummy_wr;
      Dummy_Read  = busy & bus_sel.dummy_rd;
      timeout_err = to_err_q;
      timeout_cnt = to_cnt_q;
   end

endmodule

// File: tb/tb_eth_reg_arbiter.sv
// Scoreboard bench for eth_reg_arbiter: stimulus queues expected grants/revocations, a monitor checks them.
module tb_eth_reg_arbiter;

   logic        sysclk = 1'b0;
   logic        reset;
   logic        init_done;
   logic [2:0]  req;
   logic [2:0]  grant;
   logic [1:0]  master;
   logic [23:0] offset_i;
   logic [2:0]  length_i, wr_i, newcmd_i;
   logic [47:0] wdata_i;
   logic        dummy_wr_i, dummy_rd_i;
   logic [7:0]  offset;
   logic        length, WR, NewCommand, Dummy_Write, Dummy_Read;
   logic [15:0] writeData;
   logic [3:0]  reg_state;
   logic        timeout_err;
   logic [7:0]  timeout_cnt;

   typedef struct {
      logic       is_to;
      logic [2:0] grant;
      logic [1:0] master;
      logic [7:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;

   eth_reg_arbiter #(.TIMEOUT_CYC(16), .TO_W(5)) dut (
      .sysclk(sysclk), .reset(reset), .init_done(init_done), .req(req),
      .grant(grant), .master(master), .offset_i(offset_i), .length_i(length_i),
      .wr_i(wr_i), .newcmd_i(newcmd_i), .wdata_i(wdata_i),
      .dummy_wr_i(dummy_wr_i), .dummy_rd_i(dummy_rd_i),
      .offset(offset), .length(length), .WR(WR), .writeData(writeData),
      .NewCommand(NewCommand), .Dummy_Write(Dummy_Write), .Dummy_Read(Dummy_Read),
      .reg_state(reg_state), .timeout_err(timeout_err), .timeout_cnt(timeout_cnt)
   );

   always #5 sysclk = ~sysclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge sysclk);
      #1;
   endtask

   task automatic push_grant(input logic [2:0] g, input logic [1:0] m);
      exp_t e;
      e.is_to = 1'b0; e.grant = g; e.master = m; e.cnt = 8'd0;
      exp_q.push_back(e);
   endtask

   task automatic push_to(input logic [7:0] c);
      exp_t e;
      e.is_to = 1'b1; e.grant = 3'b000; e.master = 2'b00; e.cnt = c;
      exp_q.push_back(e);
   endtask

   task automatic wait_grant(output bit found);
      found = 1'b0;
      for (int t = 0; t < 50; t++) begin
         @(negedge sysclk);
         if (grant != 3'b000) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   // Monitor: every new grant and every revocation pulse is matched against the queue head.
   initial begin
      logic [2:0] prev_g;
      exp_t e;
      prev_g = 3'b000;
      forever begin
         @(negedge sysclk);
         if (grant != 3'b000 && prev_g == 3'b000) begin
            if (exp_q.size() == 0) check("sb_unexpected_grant", 32'(grant), 32'd0);
            else begin
               e = exp_q.pop_front();
               check("sb_kind_grant", 32'(e.is_to), 32'd0);
               check("sb_grant", 32'(grant), 32'(e.grant));
               check("sb_master", 32'(master), 32'(e.master));
            end
         end
         if (timeout_err) begin
            if (exp_q.size() == 0) check("sb_unexpected_timeout", 32'(timeout_err), 32'd0);
            else begin
               e = exp_q.pop_front();
               check("sb_kind_timeout", 32'(e.is_to), 32'd1);
               check("sb_timeout_cnt", 32'(timeout_cnt), 32'(e.cnt));
            end
         end
         prev_g = grant;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      bit found;
      int bad, gap, busy_cnt;
      logic [2:0] g;

      reset = 1'b0; init_done = 1'b0; req = 3'b000;
      offset_i = {8'h3C, 8'hA5, 8'h11}; wdata_i = {16'hBEEF, 16'h1234, 16'h5555};
      length_i = 3'b101; wr_i = 3'b000; newcmd_i = 3'b000;
      dummy_wr_i = 1'b0; dummy_rd_i = 1'b0; reg_state = 4'd0;

      // Reset state
      repeat (2) @(negedge sysclk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_master", 32'(master), 32'd3);
      check("rst_length", 32'(length), 32'd1);
      check("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
      cyc();
      reset = 1'b1;

      // Pre-init gating: transmit/receive requests are ignored
      req = 3'b110;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge sysclk);
         if (grant != 3'b000 || master != 2'b11) bad++;
      end
      check("preinit_gate", 32'(bad), 32'd0);
      cyc();
      push_grant(3'b001, 2'b00);
      req = 3'b111;
      @(negedge sysclk);
      check("init_grant_not_early", 32'(grant), 32'd0);
      cyc();
      @(negedge sysclk);
      check("init_grant_latency", 32'(grant), 32'd1);
      cyc();
      req = 3'b110;
      repeat (4) cyc();

      // Init-done lockout
      req = 3'b000;
      init_done = 1'b1;
      cyc();
      init_done = 1'b0;
      req = 3'b001;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge sysclk);
         if (grant != 3'b000) bad++;
      end
      check("init_lockout", 32'(bad), 32'd0);
      cyc();
      push_grant(3'b010, 2'b01);
      req = 3'b010;
      wait_grant(found);
      check("trans_grant_found", 32'(found), 32'd1);

      // Muxed RegIO bundle and zero-latency NewCommand for the transmit grantee
      cyc();
      wr_i = 3'b010; newcmd_i = 3'b010; dummy_wr_i = 1'b1; dummy_rd_i = 1'b1;
      @(negedge sysclk);
      check("mux_offset", 32'(offset), 32'hA5);
      check("mux_length", 32'(length), 32'd0);
      check("mux_wr", 32'(WR), 32'd1);
      check("mux_wdata", 32'(writeData), 32'h1234);
      check("mux_newcmd", 32'(NewCommand), 32'd1);
      check("mux_dummy_wr", 32'(Dummy_Write), 32'd1);
      check("mux_dummy_rd_blocked", 32'(Dummy_Read), 32'd0);

      // Drain wait while RegIO is still busy
      cyc();
      req = 3'b000; reg_state = 4'd3;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         @(negedge sysclk);
         if (grant != 3'b000 || NewCommand != 1'b0 || Dummy_Write != 1'b0 ||
             master != 2'b01 || offset != 8'hA5 || WR != 1'b1) bad++;
      end
      check("drain_hold", 32'(bad), 32'd0);
      cyc();
      reg_state = 4'd0;
      @(negedge sysclk);
      check("drain_last_cycle", 32'(master), 32'd1);
      cyc();
      @(negedge sysclk);
      check("drain_exit_idle", 32'(master), 32'd3);
      cyc();
      newcmd_i = 3'b000; wr_i = 3'b000; dummy_wr_i = 1'b0; dummy_rd_i = 1'b0;

      // Round robin between transmit and receive
      push_grant(3'b100, 2'b10);
      push_grant(3'b010, 2'b01);
      push_grant(3'b100, 2'b10);
      push_grant(3'b010, 2'b01);
      req = 3'b110;
      for (int k = 0; k < 4; k++) begin
         gap = 0;
         found = 1'b0;
         for (int t = 0; t < 50; t++) begin
            @(negedge sysclk);
            if (grant != 3'b000) begin
               found = 1'b1;
               break;
            end
            gap++;
         end
         check("rr_grant_found", 32'(found), 32'd1);
         if (k > 0) check("rr_gap_min2", 32'(gap >= 2), 32'd1);
         g = grant;
         repeat (4) @(negedge sysclk);
         cyc();
         req = (k == 3) ? 3'b000 : (3'b110 & ~g);
         cyc();
         if (k < 3) req = 3'b110;
      end
      repeat (3) cyc();

      // Watchdog revocation of a stalled receive grantee
      push_grant(3'b100, 2'b10);
      push_to(8'd1);
      req = 3'b100;
      wait_grant(found);
      check("wd_grant_found", 32'(found), 32'd1);
      busy_cnt = 1;
      for (int t = 0; t < 40; t++) begin
         @(negedge sysclk);
         if (grant == 3'b100) busy_cnt++;
         else break;
      end
      check("wd_busy_cycles", 32'(busy_cnt), 32'd16);
      check("wd_timeout_pulse", 32'(timeout_err), 32'd1);
      check("wd_timeout_cnt", 32'(timeout_cnt), 32'd1);
      cyc();
      @(negedge sysclk);
      check("wd_pulse_width", 32'(timeout_err), 32'd0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge sysclk);
         if (grant != 3'b000) bad++;
      end
      check("wd_masked", 32'(bad), 32'd0);
      cyc();
      req = 3'b000;
      cyc();
      push_grant(3'b100, 2'b10);
      req = 3'b100;
      wait_grant(found);
      check("wd_unmask_regrant", 32'(found), 32'd1);

      // Asynchronous reset in the middle of a command
      cyc();
      newcmd_i = 3'b100;
      @(negedge sysclk);
      check("pre_reset_newcmd", 32'(NewCommand), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_grant", 32'(grant), 32'd0);
      check("async_rst_master", 32'(master), 32'd3);
      check("async_rst_newcmd", 32'(NewCommand), 32'd0);
      check("async_rst_offset", 32'(offset), 32'd0);
      check("async_rst_length", 32'(length), 32'd1);
      check("async_rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
      cyc();
      cyc();
      reset = 1'b1;
      newcmd_i = 3'b000;
      req = 3'b010;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge sysclk);
         if (grant != 3'b000) bad++;
      end
      check("post_reset_init_gate", 32'(bad), 32'd0);

      // init_done and req[1] together: grant two cycles later
      cyc();
      push_grant(3'b010, 2'b01);
      init_done = 1'b1;
      @(negedge sysclk);
      check("same_cycle_n", 32'(grant), 32'd0);
      cyc();
      init_done = 1'b0;
      @(negedge sysclk);
      check("same_cycle_n1", 32'(grant), 32'd0);
      cyc();
      @(negedge sysclk);
      check("same_cycle_n2", 32'(grant), 32'd2);
      cyc();
      req = 3'b000;
      repeat (3) cyc();

      @(negedge sysclk);
      check("sb_all_consumed", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
